// File: rtl/dw_fp_dot_acc.sv
// dw_fp_dot_acc: streaming floating-point dot-product accumulator.
// One fused multiply-add per accepted beat; the registered running sum
// is fed back as the addend. A vector ends on in_last or after MAX_LEN
// beats and produces one result with sticky exception status.
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   clr                   synchronous abort of the partial vector
//   in_valid/in_ready     operand beat handshake (in_a, in_b, in_last, in_rnd)
//   out_valid/out_ready   result handshake (out_z, out_status, out_count)
//
// dw_fp_dot_acc_mac carries the DW_fp_mac parameter and port list
// (a, b, c, rnd, z, status) so the DesignWare part can be dropped in by
// renaming the instance. It flushes denormals to zero in both modes.
//
// state | meaning
// EMPTY | cnt == 0, no partial vector in progress
// ACCUM | cnt  > 0, acc holds a partial sum

module dw_fp_dot_acc_mac #(
    parameter int sig_width       = 23,
    parameter int exp_width       = 8,
    parameter int ieee_compliance = 0
) (
    input  logic [sig_width+exp_width:0] a,
    input  logic [sig_width+exp_width:0] b,
    input  logic [sig_width+exp_width:0] c,
    input  logic [2:0]                   rnd,
    output logic [sig_width+exp_width:0] z,
    output logic [7:0]                   status
);
    localparam int P  = sig_width + 1;
    localparam int G  = 4;              // guard bits below the exact product
    localparam int WA = 2*P + G;
    localparam int M  = WA + 1;         // magnitude width incl. carry bit
    localparam int XW = exp_width + 8;
    localparam bit NAN_IN = (ieee_compliance != 0);
    localparam logic [exp_width-1:0] EMAX_F = '1;
    localparam logic [exp_width-1:0] EMAX_M1 = {{(exp_width-1){1'b1}}, 1'b0};
    localparam logic signed [XW-1:0] BIAS_X = XW'((1 << (exp_width-1)) - 1);
    localparam logic signed [XW-1:0] EMAX_X = XW'((1 << exp_width) - 1);

    logic sa, sb, sc;
    logic [exp_width-1:0] ea, eb, ec;
    logic [sig_width-1:0] fa, fb, fc;
    assign {sa, ea, fa} = a;
    assign {sb, eb, fb} = b;
    assign {sc, ec, fc} = c;

    logic a_zero, b_zero, c_zero, a_nan, b_nan, c_nan, a_inf, b_inf, c_inf;
    assign a_zero = (ea == '0);
    assign b_zero = (eb == '0);
    assign c_zero = (ec == '0);
    assign a_nan  = NAN_IN && (ea == EMAX_F) && (fa != '0);
    assign b_nan  = NAN_IN && (eb == EMAX_F) && (fb != '0);
    assign c_nan  = NAN_IN && (ec == EMAX_F) && (fc != '0);
    assign a_inf  = (ea == EMAX_F) && !a_nan;
    assign b_inf  = (eb == EMAX_F) && !b_nan;
    assign c_inf  = (ec == EMAX_F) && !c_nan;

    logic [P-1:0]   ma, mb, mc;
    logic [2*P-1:0] mp;
    logic           sp, prod_zero, prod_inf;
    logic signed [XW-1:0] ep_x, ec_x;
    assign ma = a_zero ? '0 : {1'b1, fa};
    assign mb = b_zero ? '0 : {1'b1, fb};
    assign mc = c_zero ? '0 : {1'b1, fc};
    assign mp = ma * mb;
    assign sp = sa ^ sb;
    assign prod_zero = a_zero | b_zero;
    assign prod_inf  = a_inf | b_inf;
    assign ep_x = XW'(ea) + XW'(eb) - BIAS_X;
    assign ec_x = XW'(ec);

    // Right shift with every bit shifted out jammed into bit 0.
    function automatic logic [WA-1:0] shr_sticky(input logic [WA-1:0] x, input logic [XW-1:0] sh);
        logic [WA-1:0] mask;
        if (sh >= XW'(WA))
            return {{(WA-1){1'b0}}, |x};
        mask = ~({WA{1'b1}} << sh);
        return (x >> sh) | {{(WA-1){1'b0}}, |(x & mask)};
    endfunction

    logic signed [XW-1:0] d, emax, er, er_f;
    logic [XW-1:0] sh_p, sh_c, lz;
    logic [WA-1:0] xp_al, xc_al;
    logic [M:0]    vp, vc, sum;
    logic [M-1:0]  mag, norm;
    logic [P-1:0]  mant;
    logic [P:0]    mant_r;
    logic          neg, s, rbit, stk, inc, found, to_inf;
    logic [sig_width-1:0] frac;

    always_comb begin
        z = '0; status = '0;
        d = ep_x - ec_x;
        emax = ep_x; sh_p = '0; sh_c = '0;
        if (c_zero)         emax = ep_x;
        else if (prod_zero) emax = ec_x;
        else if (d >= 0)    sh_c = d;
        else begin
            emax = ec_x;
            sh_p = -d;
        end
        xp_al = shr_sticky({mp, {G{1'b0}}}, sh_p);
        xc_al = shr_sticky({1'b0, mc, {(sig_width+G){1'b0}}}, sh_c);
        vp = {2'b00, xp_al};
        vc = {2'b00, xc_al};
        if (sp) vp = -vp;
        if (sc) vc = -vc;
        sum  = vp + vc;
        neg  = sum[M];
        mag  = M'(neg ? -sum : sum);
        lz = '0; found = 1'b0;
        for (int i = M-1; i >= 0; i--) begin
            if (!found && mag[i]) begin
                lz = XW'(M-1-i);
                found = 1'b1;
            end
        end
        norm = mag << lz;
        mant = norm[M-1 -: P];
        rbit = norm[M-1-P];
        stk  = |norm[M-2-P:0];
        s    = neg;
        case (rnd)
            3'd1:    inc = 1'b0;
            3'd2:    inc = !s & (rbit | stk);
            3'd3:    inc = s & (rbit | stk);
            3'd4:    inc = rbit;
            3'd5:    inc = rbit | stk;
            default: inc = rbit & (stk | mant[0]);
        endcase
        mant_r = {1'b0, mant} + (P+1)'(inc);
        er     = emax + XW'(2) - lz;
        er_f   = er + XW'(mant_r[P]);
        frac   = mant_r[P] ? mant_r[sig_width:1] : mant_r[sig_width-1:0];
        to_inf = !((rnd == 3'd1) || (rnd == 3'd2 && s) || (rnd == 3'd3 && !s));

        if (a_nan | b_nan | c_nan | (prod_inf & prod_zero) |
            (prod_inf & c_inf & (sp != sc))) begin
            z = {1'b0, EMAX_F, 1'b1, {(sig_width-1){1'b0}}};
            status[2] = 1'b1;
        end else if (prod_inf | c_inf) begin
            z = {prod_inf ? sp : sc, EMAX_F, {sig_width{1'b0}}};
            status[1] = 1'b1;
        end else if (mag == '0) begin
            // Exact zero keeps a common operand sign, otherwise it takes the rounding sign.
            if (prod_zero && c_zero && (sp == sc)) z[sig_width+exp_width] = sp;
            else                                   z[sig_width+exp_width] = (rnd == 3'd3);
            status[0] = 1'b1;
        end else if (er_f >= EMAX_X) begin
            z = to_inf ? {s, EMAX_F, {sig_width{1'b0}}} : {s, EMAX_M1, {sig_width{1'b1}}};
            status[1] = to_inf;
            status[4] = 1'b1;
            status[5] = 1'b1;
        end else if (er_f <= 0) begin
            z[sig_width+exp_width] = s;
            status[0] = 1'b1;
            status[3] = 1'b1;
            status[5] = 1'b1;
        end else begin
            z = {s, er_f[exp_width-1:0], frac};
            status[5] = rbit | stk;
        end
    end
endmodule

module dw_fp_dot_acc #(
    parameter int SIG_WIDTH       = 23,
    parameter int EXP_WIDTH       = 8,
    parameter int IEEE_COMPLIANCE = 0,
    parameter int MAX_LEN         = 256
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           clr,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [SIG_WIDTH+EXP_WIDTH:0]   in_a,
    input  logic [SIG_WIDTH+EXP_WIDTH:0]   in_b,
    input  logic                           in_last,
    input  logic [2:0]                     in_rnd,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [SIG_WIDTH+EXP_WIDTH:0]   out_z,
    output logic [7:0]                     out_status,
    output logic [$clog2(MAX_LEN+1)-1:0]   out_count
);
    localparam int CW = $clog2(MAX_LEN+1);
    localparam int N  = SIG_WIDTH + EXP_WIDTH + 1;
    localparam logic [0:0] EMPTY = 1'b0;
    localparam logic [0:0] ACCUM = 1'b1;

    logic [N-1:0]  acc, mac_z;
    logic [CW-1:0] cnt;
    logic [2:0]    rnd_q, rnd_use;
    logic [7:1]    sticky;
    logic [7:0]    mac_status;
    logic [0:0]    state;
    logic          beat, terminal;

    assign state    = (cnt == '0) ? EMPTY : ACCUM;
    assign in_ready = !out_valid | out_ready;
    assign beat     = in_valid & in_ready & !clr;
    // The first beat rounds with its own in_rnd; later beats use the latched copy.
    assign rnd_use  = (state == EMPTY) ? in_rnd : rnd_q;
    assign terminal = in_last | (cnt == CW'(MAX_LEN-1));

    dw_fp_dot_acc_mac #(
        .sig_width       (SIG_WIDTH),
        .exp_width       (EXP_WIDTH),
        .ieee_compliance (IEEE_COMPLIANCE)
    ) u_mac (
        .a      (in_a),
        .b      (in_b),
        .c      (acc),
        .rnd    (rnd_use),
        .z      (mac_z),
        .status (mac_status)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc        <= '0;
            cnt        <= '0;
            rnd_q      <= '0;
            sticky     <= '0;
            out_valid  <= 1'b0;
            out_z      <= '0;
            out_status <= '0;
            out_count  <= '0;
        end else begin
            if (out_valid & out_ready)
                out_valid <= 1'b0;
            if (clr) begin
                acc    <= '0;
                cnt    <= '0;
                sticky <= '0;
            end else if (beat) begin
                if (state == EMPTY)
                    rnd_q <= in_rnd;
                if (terminal) begin
                    out_z      <= mac_z;
                    out_status <= {sticky | mac_status[7:1], mac_status[0]};
                    out_count  <= cnt + CW'(1);
                    out_valid  <= 1'b1;
                    acc        <= '0;
                    cnt        <= '0;
                    sticky     <= '0;
                end else begin
                    acc    <= mac_z;
                    cnt    <= cnt + CW'(1);
                    sticky <= sticky | mac_status[7:1];
                end
            end
        end
    end
endmodule

// File: tb/tb_dw_fp_dot_acc.sv
// Directed bench for dw_fp_dot_acc built with MAX_LEN = 4 so that the
// auto-terminate case is reachable in a few beats.
module tb_dw_fp_dot_acc;
    localparam int SW   = 23;
    localparam int EW   = 8;
    localparam int N    = SW + EW + 1;
    localparam int MAXL = 4;
    localparam int CW   = $clog2(MAXL+1);

    logic          clk = 1'b0;
    logic          rst_n, clr, in_valid, in_ready, in_last, out_valid, out_ready;
    logic [N-1:0]  in_a, in_b, out_z;
    logic [2:0]    in_rnd;
    logic [7:0]    out_status;
    logic [CW-1:0] out_count;

    int n_checks = 0;
    int n_errors = 0;

    dw_fp_dot_acc #(
        .SIG_WIDTH(SW), .EXP_WIDTH(EW), .IEEE_COMPLIANCE(0), .MAX_LEN(MAXL)
    ) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_last(in_last), .in_rnd(in_rnd),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_z(out_z), .out_status(out_status), .out_count(out_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic last, input logic [2:0] rnd);
        in_valid = 1'b1; in_a = a; in_b = b; in_last = last; in_rnd = rnd;
    endtask

    task automatic idle();
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; clr = 1'b0; in_a = '0; in_b = '0; in_rnd = '0;
        out_ready = 1'b1;
        idle();
        step(); step();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_z", out_z, 0);
        chk("rst_out_status", out_status, 0);
        chk("rst_out_count", out_count, 0);
        chk("rst_in_ready", in_ready, 1);
        rst_n = 1'b1;
        step();

        // 1*2 + 3*4 = 14
        drive(32'h3F800000, 32'h40000000, 1'b0, 3'd0); step();
        chk("t1_no_early_valid", out_valid, 0);
        drive(32'h40400000, 32'h40800000, 1'b1, 3'd0); step(); idle();
        chk("t1_valid", out_valid, 1);
        chk("t1_z", out_z, 32'h41600000);
        chk("t1_count", out_count, 2);
        chk("t1_status", out_status, 0);
        step();
        chk("t1_taken", out_valid, 0);

        // auto-terminate at 4 beats, then 3 more beats closed by last
        for (int i = 0; i < 4; i++) begin
            drive(32'h3F800000, 32'h3F800000, 1'b0, 3'd0); step();
        end
        chk("t2_auto_valid", out_valid, 1);
        chk("t2_auto_z", out_z, 32'h40800000);
        chk("t2_auto_count", out_count, 4);
        drive(32'h3F800000, 32'h3F800000, 1'b0, 3'd0); step();
        chk("t2_beat5_no_result", out_valid, 0);
        drive(32'h3F800000, 32'h3F800000, 1'b0, 3'd0); step();
        drive(32'h3F800000, 32'h3F800000, 1'b1, 3'd0); step(); idle();
        chk("t2_last_z", out_z, 32'h40400000);
        chk("t2_last_count", out_count, 3);

        // backpressure with a beat waiting at the input
        out_ready = 1'b0;
        drive(32'h40400000, 32'h40400000, 1'b1, 3'd0);
        #1;
        chk("t3_stall_ready", in_ready, 0);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t3_hold_ready", in_ready, 0);
            chk("t3_hold_valid", out_valid, 1);
            chk("t3_hold_z", out_z, 32'h40400000);
            chk("t3_hold_count", out_count, 3);
        end
        out_ready = 1'b1;
        #1;
        chk("t3_release_ready", in_ready, 1);
        step(); idle();
        chk("t3_next_valid", out_valid, 1);
        chk("t3_next_z", out_z, 32'h41100000);
        chk("t3_next_count", out_count, 1);
        step();
        chk("t3_drained", out_valid, 0);

        // overflow to +inf then +inf + -inf: huge retained, invalid raised
        drive(32'h7F000000, 32'h40000000, 1'b0, 3'd0); step();
        drive(32'hFF800000, 32'h3F800000, 1'b1, 3'd0); step(); idle();
        chk("t4_huge_invalid_zero", {29'd0, out_status[4], out_status[2], out_status[0]}, 3'b110);
        chk("t4_count", out_count, 2);

        // clr coincident with beat 2 discards the partial vector
        drive(32'h40000000, 32'h40000000, 1'b0, 3'd0); step();
        clr = 1'b1;
        drive(32'h40000000, 32'h40000000, 1'b0, 3'd0); step();
        clr = 1'b0;
        chk("t5_clr_no_result", out_valid, 0);
        drive(32'h3F800000, 32'h3F800000, 1'b1, 3'd0); step(); idle();
        chk("t5_z", out_z, 32'h3F800000);
        chk("t5_count", out_count, 1);

        // 1.0 + 1.5*2^-24: RNE rounds up, RZ truncates; only the first beat's in_rnd counts
        drive(32'h3F800000, 32'h3F800000, 1'b0, 3'd0); step();
        drive(32'h33C00000, 32'h3F800000, 1'b1, 3'd1); step(); idle();
        chk("t6_rne_z", out_z, 32'h3F800001);
        chk("t6_rne_status", out_status, 32'h20);
        drive(32'h3F800000, 32'h3F800000, 1'b0, 3'd1); step();
        drive(32'h33C00000, 32'h3F800000, 1'b1, 3'd0); step(); idle();
        chk("t6_rz_z", out_z, 32'h3F800000);
        chk("t6_rz_status", out_status, 32'h20);

        // async reset mid-vector
        for (int i = 0; i < 3; i++) begin
            drive(32'h3F800000, 32'h3F800000, 1'b0, 3'd0); step();
        end
        idle();
        #2;
        rst_n = 1'b0;
        #1;
        chk("t7_rst_valid", out_valid, 0);
        chk("t7_rst_z", out_z, 0);
        chk("t7_rst_status", out_status, 0);
        chk("t7_rst_count", out_count, 0);
        chk("t7_rst_ready", in_ready, 1);
        #4;
        rst_n = 1'b1;
        step();
        drive(32'h40400000, 32'h40400000, 1'b1, 3'd0); step(); idle();
        chk("t7_after_valid", out_valid, 1);
        chk("t7_after_z", out_z, 32'h41100000);
        chk("t7_after_count", out_count, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
